// File: rtl/cpu_pkg.sv
// Shared core types and constants.
// Used by the fetch stage and its prefetch queue.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
      logic            filled;
   } fetch_entry_t;

   // Counter width able to hold 0 .. 2*depth.
   function automatic int cnt_width(input int depth);
      return $clog2(2 * depth + 1);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Reservation ring between instruction memory and decode.
// Reserve at tail, fill oldest unfilled, pop head, flush all.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic            fill,
   input  logic [XLEN-1:0] fill_data,
   input  logic            pop,
   output logic            full,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

   fetch_entry_t ring [DEPTH];

   logic [AW:0] head;
   logic [AW:0] tail;
   logic [AW:0] fptr;
   logic [AW:0] used;
   logic        fill_ok;

   assign used    = tail - head;
   assign full    = (used == CAP);
   assign fill_ok = fill && (fptr != tail);

   assign head_valid = (head != tail)
                    && ring[head[AW-1:0]].filled;
   assign head_pc    = ring[head[AW-1:0]].pc;
   assign head_data  = ring[head[AW-1:0]].data;

   // Ring storage and pointers; a flush drops every entry.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head <= '0;
         tail <= '0;
         fptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ring[i] <= '0;
         end
      end else begin
         if (push) begin
            ring[tail[AW-1:0]].pc     <= push_pc;
            ring[tail[AW-1:0]].data   <= '0;
            ring[tail[AW-1:0]].filled <= 1'b0;
            tail <= tail + ONE;
         end
         if (fill_ok) begin
            ring[fptr[AW-1:0]].data   <= fill_data;
            ring[fptr[AW-1:0]].filled <= 1'b1;
            fptr <= fptr + ONE;
         end
         if (pop) begin
            head <= head + ONE;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request credits and squash
// accounting around the reservation-based prefetch queue.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            ins_valid,
   output logic [XLEN-1:0] ins_out,
   output logic [XLEN-1:0] ins_pc,
   input  logic            ins_ready
);

   localparam int            CW      = cnt_width(DEPTH);
   localparam logic [CW-1:0] MAX_OUT = CW'(2 * DEPTH);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   inflight_nxt;
   logic [CW-1:0]   drop_cnt;
   logic            warm;
   logic            full;
   logic            fire;
   logic            pop;
   logic            push;
   logic            fill;

   assign target_pc = redirect_pc & ~32'h3;

   assign imem_req_valid = !rst && warm && !full
                        && (inflight < MAX_OUT);
   assign imem_req_addr  = fetch_pc;

   assign fire = imem_req_valid && imem_req_ready;
   assign pop  = ins_valid && ins_ready;
   assign push = fire && !redirect_valid;
   assign fill = imem_rsp_valid && (drop_cnt == '0)
              && !redirect_valid;

   assign inflight_nxt = inflight + CW'(fire)
                       - CW'(imem_rsp_valid);

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_pc    (fetch_pc),
      .fill       (fill),
      .fill_data  (imem_rsp_data),
      .pop        (pop),
      .full       (full),
      .head_valid (ins_valid),
      .head_pc    (ins_pc),
      .head_data  (ins_out)
   );

   // PC, outstanding count and squash count. On redirect every
   // response still owed by memory is old-path, including ones
   // already marked for dropping, so drop_cnt becomes inflight.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         warm     <= 1'b0;
      end else begin
         warm     <= 1'b1;
         inflight <= inflight_nxt;
         if (redirect_valid) begin
            fetch_pc <= target_pc;
            drop_cnt <= inflight_nxt;
         end else begin
            if (fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - C_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks for fetch_unit with an
// in-order variable-latency memory model and a PC scoreboard.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        ins_valid;
   logic [31:0] ins_out;
   logic [31:0] ins_pc;
   logic        ins_ready = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(
      .DEPTH(4),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ins_valid      (ins_valid),
      .ins_out        (ins_out),
      .ins_pc         (ins_pc),
      .ins_ready      (ins_ready)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pend[$];
   logic [31:0] fires[$];
   logic [31:0] pops_pc[$];
   int          pops_cyc[$];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_due = -1;
   int          lat = 1;
   bit          rnd = 1'b0;
   logic        ready_val = 1'b0;
   logic        rdy_val = 1'b0;
   logic [31:0] exp_pc = '0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h5A5A_1357;
   endfunction

   function automatic logic [31:0] qpc(input int i);
      return (i < pops_pc.size()) ? pops_pc[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] qcyc(input int i);
      return (i < pops_cyc.size()) ? pops_cyc[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] qfire(input int i);
      return (i < fires.size()) ? fires[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One cycle: called at a negedge, returns at the next one.
   task automatic step();
      req_t r;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memf(pend[0].addr);
         void'(pend.pop_front());
      end
      if (rnd) begin
         imem_req_ready = ($urandom_range(0, 9) < 7);
         ins_ready      = ($urandom_range(0, 9) < 6);
         lat            = $urandom_range(1, 4);
      end else begin
         imem_req_ready = ready_val;
         ins_ready      = rdy_val;
      end
      #1;
      if (ins_valid && ins_ready) begin
         check("sb_pc", ins_pc, exp_pc);
         check("sb_data", ins_out, memf(exp_pc));
         pops_pc.push_back(ins_pc);
         pops_cyc.push_back(cyc);
         exp_pc += 32'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
         r.addr = imem_req_addr;
         r.due  = (cyc + lat > last_due) ? cyc + lat
                                         : last_due + 1;
         last_due = r.due;
         pend.push_back(r);
         fires.push_back(imem_req_addr);
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rnd = 1'b0;
      ready_val = 1'b0;
      rdy_val = 1'b0;
      redirect_valid = 1'b0;
      rst = 1'b1;
      lat = 1;
      pend.delete();
      last_due = -1;
      repeat (3) step();
      #1;
      check("rst_ins_valid", ins_valid, 32'd0);
      check("rst_req_valid", imem_req_valid, 32'd0);
      check("rst_ins_out", ins_out, 32'd0);
      check("rst_ins_pc", ins_pc, 32'd0);
      rst = 1'b0;
      cyc = 0;
      last_due = -1;
      exp_pc = 32'h0;
      fires.delete();
      pops_pc.delete();
      pops_cyc.delete();
      #1;
      check("c0_req_valid", imem_req_valid, 32'd0);
      check("c0_ins_valid", ins_valid, 32'd0);
      check("c0_req_addr", imem_req_addr, 32'd0);
   endtask

   initial begin
      int n;
      @(negedge clk);

      // Streaming, 1-cycle memory, decoder always ready.
      do_reset();
      ready_val = 1'b1;
      rdy_val = 1'b1;
      repeat (11) step();
      check("t1_npops", pops_pc.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t1_cyc%0d", i), qcyc(i), 3 + i);
         check($sformatf("t1_pc%0d", i), qpc(i), 4 * i);
      end

      // Decoder stalled: queue fills with 4 requests.
      do_reset();
      ready_val = 1'b1;
      rdy_val = 1'b0;
      repeat (12) step();
      check("t2_nfires", fires.size(), 32'd4);
      check("t2_req_off", imem_req_valid, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_fire%0d", i), qfire(i), 4 * i);
      end
      rdy_val = 1'b1;
      repeat (10) step();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_pop%0d", i), qpc(i), 4 * i);
      end
      check("t2_resume", qfire(4), 32'h10);

      // 3-cycle memory, redirect with old requests in flight.
      do_reset();
      lat = 3;
      ready_val = 1'b1;
      rdy_val = 1'b1;
      repeat (3) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect_valid = 1'b0;
      repeat (10) step();
      check("t3_first_pc", qpc(0), 32'h100);
      check("t3_first_cyc", qcyc(0), 32'd8);
      n = 0;
      foreach (pops_pc[i]) begin
         if (pops_pc[i] == 32'h8 || pops_pc[i] == 32'hC) n++;
      end
      check("t3_stale", n, 32'd0);

      // Redirect coinciding with a fire and a response.
      do_reset();
      ready_val = 1'b1;
      rdy_val = 1'b1;
      repeat (2) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect_valid = 1'b0;
      repeat (6) step();
      check("t4a_pc0", qpc(0), 32'h200);
      check("t4a_cyc0", qcyc(0), 32'd5);
      check("t4a_pc1", qpc(1), 32'h204);
      check("t4a_fire2", qfire(2), 32'h200);

      // Redirect coinciding with a pop.
      do_reset();
      ready_val = 1'b1;
      rdy_val = 1'b1;
      repeat (5) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      step();
      redirect_valid = 1'b0;
      repeat (6) step();
      check("t4b_pc2", qpc(2), 32'h8);
      check("t4b_cyc2", qcyc(2), 32'd5);
      check("t4b_pc3", qpc(3), 32'h300);
      check("t4b_cyc3", qcyc(3), 32'd8);

      // Unaligned redirect near the top of the address space.
      do_reset();
      ready_val = 1'b1;
      rdy_val = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      step();
      redirect_valid = 1'b0;
      repeat (5) step();
      check("t5_fire0", qfire(0), 32'hFFFF_FFFC);
      check("t5_pc0", qpc(0), 32'hFFFF_FFFC);
      check("t5_cyc0", qcyc(0), 32'd3);
      check("t5_pc1", qpc(1), 32'h0);

      // Random backpressure, latency and redirects.
      do_reset();
      rnd = 1'b1;
      for (int i = 0; i < 800; i++) begin
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom;
         step();
      end
      redirect_valid = 1'b0;
      rnd = 1'b0;
      check("t6_progress", pops_pc.size() > 50, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
